// File: rtl/icmp_pkg.sv
// icmp_pkg: shared ICMP definitions for the receive checker and its checksum helper.
// Contents: FSM state encoding, message geometry, ICMP type codes, counter helper.
package icmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_HOLD
    } state_t;

    localparam int          ICMP_WORDS           = 5;
    localparam logic [7:0]  ICMP_TYPE_ECHO_REQ   = 8'd8;
    localparam logic [7:0]  ICMP_TYPE_ECHO_REPLY = 8'd0;
    localparam logic [15:0] CSUM_GOOD            = 16'hFFFF;
    localparam logic [15:0] CNT_MAX              = 16'hFFFF;

    // Statistics stick at the top value instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icmp_rx_checker_if.sv
// icmp_rx_checker_if: word stream in, decoded message out, plus statistics.
// Signals:
//   in_word/in_sop/in_valid -> in_ready        : upstream word handshake
//   out_valid -> out_ready                      : decoded message handshake
//   msg_type, msg_code, msg_typedata            : decoded header fields
//   chk_ok, is_echo_req                         : checksum verdict, echo request flag
//   good_cnt, bad_cnt, abort_cnt                : saturating statistics
// Modports: master = traffic source / consumer, slave = the checker.
interface icmp_rx_checker_if;

    logic [31:0] in_word;
    logic        in_sop;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  msg_type;
    logic [7:0]  msg_code;
    logic [31:0] msg_typedata;
    logic        chk_ok;
    logic        is_echo_req;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
    logic [15:0] abort_cnt;

    modport master (
        output in_word, in_sop, in_valid, out_ready,
        input  in_ready, out_valid, msg_type, msg_code, msg_typedata,
        input  chk_ok, is_echo_req, good_cnt, bad_cnt, abort_cnt
    );

    modport slave (
        input  in_word, in_sop, in_valid, out_ready,
        output in_ready, out_valid, msg_type, msg_code, msg_typedata,
        output chk_ok, is_echo_req, good_cnt, bad_cnt, abort_cnt
    );

endinterface

// File: rtl/icmp_csum_acc.sv
// icmp_csum_acc: one's-complement checksum accumulator over 32-bit words.
// Ports:
//   clock, actreset : clock, asynchronous active-high reset
//   clear           : restart the sum (combined with add, the word starts a new sum)
//   add             : add both halfwords of word this cycle
//   word            : 32-bit data word
//   sum             : accumulator folded twice to 16 bits
module icmp_csum_acc (
    input  logic        clock,
    input  logic        actreset,
    input  logic        clear,
    input  logic        add,
    input  logic [31:0] word,
    output logic [15:0] sum
);

    logic [19:0] acc;
    logic [19:0] halves;
    logic [16:0] fold1;

    assign halves = {4'd0, word[31:16]} + {4'd0, word[15:0]};

    always_ff @(posedge clock or posedge actreset) begin
        if (actreset)
            acc <= '0;
        else if (clear || add)
            acc <= (clear ? 20'd0 : acc) + (add ? halves : 20'd0);
    end

    // 20 bits hold ten halfwords; two folds bring any such sum into 16 bits.
    assign fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    assign sum   = fold1[15:0] + {15'd0, fold1[16]};

endmodule

// File: rtl/icmp_rx_checker.sv
// icmp_rx_checker: collects 5-word ICMP messages, verifies the checksum, decodes the header.
// Ports:
//   clock    : rising-edge clock
//   actreset : asynchronous active-high reset
//   bus      : icmp_rx_checker_if.slave (input stream, decoded output, statistics)
module icmp_rx_checker
    import icmp_pkg::*;
(
    input logic              clock,
    input logic              actreset,
    icmp_rx_checker_if.slave bus
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  idx;
    logic        accept;
    logic        sop_take;
    logic        word_take;
    logic        last_word;
    logic        handshake;
    logic        csum_ok;
    logic [15:0] csum;

    assign accept    = bus.in_valid && bus.in_ready;
    assign sop_take  = accept && bus.in_sop;
    assign word_take = accept && !bus.in_sop && state == ST_COLLECT;
    assign last_word = word_take && idx == 3'(ICMP_WORDS - 1);
    assign handshake = bus.out_valid && bus.out_ready;
    assign csum_ok   = csum == CSUM_GOOD;

    // Upstream stalls through CHECK and HOLD, so nothing is dropped there.
    assign bus.in_ready = !actreset && (state == ST_IDLE || state == ST_COLLECT);

    icmp_csum_acc u_csum (
        .clock    (clock),
        .actreset (actreset),
        .clear    (sop_take),
        .add      (sop_take || word_take),
        .word     (bus.in_word),
        .sum      (csum)
    );

    always_ff @(posedge clock or posedge actreset) begin
        if (actreset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    state_next = sop_take ? ST_COLLECT : ST_IDLE;
            ST_COLLECT: state_next = last_word ? ST_CHECK : ST_COLLECT;
            ST_CHECK:   state_next = ST_HOLD;
            ST_HOLD:    state_next = handshake ? ST_IDLE : ST_HOLD;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge actreset) begin
        if (actreset) begin
            idx              <= '0;
            bus.out_valid    <= 1'b0;
            bus.msg_type     <= '0;
            bus.msg_code     <= '0;
            bus.msg_typedata <= '0;
            bus.chk_ok       <= 1'b0;
            bus.is_echo_req  <= 1'b0;
            bus.good_cnt     <= '0;
            bus.bad_cnt      <= '0;
            bus.abort_cnt    <= '0;
        end else begin
            // A start-of-message word always restarts, even mid-message.
            if (sop_take) begin
                bus.msg_type <= bus.in_word[31:24];
                bus.msg_code <= bus.in_word[23:16];
                idx          <= 3'd1;
            end else if (word_take) begin
                if (idx == 3'd1)
                    bus.msg_typedata <= bus.in_word;
                idx <= idx + 3'd1;
            end
            if (sop_take && state == ST_COLLECT)
                bus.abort_cnt <= sat_inc(bus.abort_cnt);
            if (state == ST_CHECK) begin
                bus.chk_ok      <= csum_ok;
                bus.is_echo_req <= csum_ok && bus.msg_type == ICMP_TYPE_ECHO_REQ && bus.msg_code == 8'd0;
                if (csum_ok)
                    bus.good_cnt <= sat_inc(bus.good_cnt);
                else
                    bus.bad_cnt <= sat_inc(bus.bad_cnt);
            end
            // Registered valid: rises one cycle into HOLD, once the verdict is settled.
            bus.out_valid <= state == ST_HOLD && !handshake;
        end
    end

endmodule

// File: tb/tb_icmp_rx_checker.sv
// tb_icmp_rx_checker: randomized bench for icmp_rx_checker with a message-level reference model.
module tb_icmp_rx_checker;

    typedef struct {
        logic [4:0][31:0] w;
        int               good;
        int               bad;
        int               abort;
    } exp_t;

    logic clock = 1'b0;
    logic actreset;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_good = 0;
    int   n_bad = 0;
    int   n_abort = 0;
    bit   gaps = 0;
    bit   rdy_rand = 0;
    bit   rdy_val = 1;
    exp_t exp_q[$];

    icmp_rx_checker_if bus ();

    icmp_rx_checker dut (
        .clock    (clock),
        .actreset (actreset),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // One's-complement sum of all ten halfwords, folded until it fits in 16 bits.
    function automatic int unsigned ones_sum(input logic [4:0][31:0] w);
        int unsigned s = 0;
        for (int i = 0; i < 5; i++)
            s += 32'(w[i][31:16]) + 32'(w[i][15:0]);
        while ((s >> 16) != 0)
            s = (s & 32'hFFFF) + (s >> 16);
        return s;
    endfunction

    function automatic bit ref_ok(input logic [4:0][31:0] w);
        return ones_sum(w) == 32'hFFFF;
    endfunction

    function automatic logic [4:0][31:0] make_msg(input bit good, input bit echo);
        logic [4:0][31:0] w;
        int unsigned      s;
        for (int i = 1; i < 5; i++)
            w[i] = $urandom;
        w[0] = {echo ? 16'h0800 : 16'($urandom), 16'h0000};
        s = ones_sum(w);
        w[0][15:0] = good ? ~s[15:0] : 16'($urandom);
        return w;
    endfunction

    task automatic put(input logic [31:0] word, input logic sop);
        bit acc;
        int t = 0;
        bus.in_word  = word;
        bus.in_sop   = sop;
        bus.in_valid = 1'b1;
        do begin
            acc = bus.in_ready;
            @(negedge clock);
            t++;
        end while (!acc && t < 500);
        check("put_accept", acc, 1);
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        if (gaps)
            repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    task automatic send_msg(input logic [4:0][31:0] w);
        exp_t e;
        if (ref_ok(w))
            n_good++;
        else
            n_bad++;
        e.w     = w;
        e.good  = n_good;
        e.bad   = n_bad;
        e.abort = n_abort;
        exp_q.push_back(e);
        for (int i = 0; i < 5; i++)
            put(w[i], i == 0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        check("drain", 64'(exp_q.size()), 0);
        repeat (2) @(negedge clock);
    endtask

    // Consumer and output monitor: both handshake signals are stable from here to the next rising edge.
    initial begin
        exp_t e;
        bit   ok;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clock);
            bus.out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_val;
            if (!actreset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", bus.out_valid, 0);
                end else begin
                    e  = exp_q.pop_front();
                    ok = ref_ok(e.w);
                    check("msg_type", bus.msg_type, e.w[0][31:24]);
                    check("msg_code", bus.msg_code, e.w[0][23:16]);
                    check("msg_typedata", bus.msg_typedata, e.w[1]);
                    check("chk_ok", bus.chk_ok, ok);
                    check("is_echo_req", bus.is_echo_req, ok && e.w[0][31:16] == 16'h0800);
                    check("good_cnt", bus.good_cnt, sat16(e.good));
                    check("bad_cnt", bus.bad_cnt, sat16(e.bad));
                    check("abort_cnt", bus.abort_cnt, sat16(e.abort));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

    initial begin
        logic [4:0][31:0] bad_w;
        logic [50:0]      snap;
        logic [47:0]      cnt_snap;
        int               t;
        int               k;
        bus.in_word  = '0;
        bus.in_sop   = 1'b0;
        bus.in_valid = 1'b0;
        actreset     = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_msg", {bus.out_valid, bus.msg_type, bus.msg_code, bus.msg_typedata, bus.chk_ok, bus.is_echo_req}, 0);
        check("rst_cnt", {bus.good_cnt, bus.bad_cnt, bus.abort_cnt}, 0);
        actreset = 1'b0;
        @(negedge clock);
        check("rel_in_ready", bus.in_ready, 1);

        // Known-good echo request, with latency from the last accepted word.
        send_msg({32'h0, 32'h0, 32'h0, 32'h00010002, 32'h0800F7FC});
        check("lat_n0", bus.out_valid, 0);
        @(negedge clock);
        check("lat_n1", bus.out_valid, 0);
        @(negedge clock);
        check("lat_n2", bus.out_valid, 1);
        check("echo_flag", bus.is_echo_req, 1);
        drain();

        // Same message with a corrupted checksum.
        bad_w = {32'h0, 32'h0, 32'h0, 32'h00010002, 32'h0800F7FD};
        send_msg(bad_w);
        drain();
        check("bad_one", bus.bad_cnt, 1);

        // Consumer back-pressure for ten cycles.
        rdy_val = 0;
        send_msg(make_msg(1, 1));
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("hold_wait", bus.out_valid, 1);
        snap     = {bus.msg_type, bus.msg_code, bus.msg_typedata, bus.chk_ok, bus.is_echo_req, 1'b1};
        cnt_snap = {bus.good_cnt, bus.bad_cnt, bus.abort_cnt};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_ov", bus.out_valid, 1);
            check("hold_ir", bus.in_ready, 0);
            check("hold_msg", {bus.msg_type, bus.msg_code, bus.msg_typedata, bus.chk_ok, bus.is_echo_req, 1'b1}, snap);
            check("hold_cnt", {bus.good_cnt, bus.bad_cnt, bus.abort_cnt}, cnt_snap);
        end
        rdy_val = 1;
        repeat (2) @(negedge clock);
        check("hold_release_ir", bus.in_ready, 1);
        check("hold_release_ov", bus.out_valid, 0);

        // Random traffic: stray words in idle, aborted partial messages, gaps, random consumer.
        gaps     = 1;
        rdy_rand = 1;
        for (int m = 0; m < 120; m++) begin
            if ($urandom_range(0, 4) == 0)
                put($urandom, 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(1, 4);
                put($urandom, 1'b1);
                for (int j = 1; j < k; j++)
                    put($urandom, 1'b0);
                n_abort++;
            end
            send_msg(make_msg($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1));
        end
        drain();
        gaps     = 0;
        rdy_rand = 0;
        rdy_val  = 1;
        check("end_good", bus.good_cnt, sat16(n_good));
        check("end_bad", bus.bad_cnt, sat16(n_bad));
        check("end_abort", bus.abort_cnt, sat16(n_abort));

        // Reset after two words of a message.
        put(32'h0800_1234, 1'b1);
        put(32'hCAFE_F00D, 1'b0);
        actreset = 1'b1;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_msg", {bus.out_valid, bus.msg_type, bus.msg_code, bus.msg_typedata, bus.chk_ok, bus.is_echo_req}, 0);
        check("mid_rst_cnt", {bus.good_cnt, bus.bad_cnt, bus.abort_cnt}, 0);
        n_good  = 0;
        n_bad   = 0;
        n_abort = 0;
        @(negedge clock);
        actreset = 1'b0;
        #1;
        check("mid_rel_in_ready", bus.in_ready, 1);
        @(negedge clock);
        send_msg(make_msg(1, 0));
        drain();

        // Restart on the third word of a message, then a full good message.
        actreset = 1'b1;
        @(negedge clock);
        actreset = 1'b0;
        n_good   = 0;
        n_bad    = 0;
        n_abort  = 0;
        @(negedge clock);
        put(32'h0800_0000, 1'b1);
        put(32'h1111_2222, 1'b0);
        n_abort++;
        send_msg({32'h0, 32'h0, 32'h0, 32'h00010002, 32'h0800F7FC});
        drain();
        check("abort_one", bus.abort_cnt, 1);
        check("abort_good", bus.good_cnt, 1);

        // Saturation: preload the bad counter near the top instead of sending 65535 messages.
        force bus.bad_cnt = 16'hFFFB;
        @(negedge clock);
        release bus.bad_cnt;
        n_bad = 65531;
        check("sat_preload", bus.bad_cnt, 16'hFFFB);
        for (int i = 0; i < 6; i++)
            send_msg(bad_w);
        drain();
        check("bad_sat", bus.bad_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icmp_rx_checker.md
ICMP_RX_CHECKER -- requirements
Module: icmp_rx_checker

Interface
REQ-001 SHALL: clock  input  1  rising-edge clock for all sequential logic.
REQ-002 SHALL: actreset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: in_word  input  32  ICMP message word, header word first.
REQ-004 SHALL: in_sop  input  1  marks in_word as word 0 (type, code, checksum).
REQ-005 SHALL: in_valid  input  1  in_word/in_sop valid this cycle.
REQ-006 SHALL: in_ready  output  1  word accepted when in_valid && in_ready.
REQ-007 SHALL: out_valid  output  1  decoded message available.
REQ-008 SHALL: out_ready  input  1  consumer takes message when out_valid && out_ready.
REQ-009 SHALL: msg_type / msg_code  output  8 / 8  from word 0 [31:24] / [23:16].
REQ-010 SHALL: msg_typedata  output  32  word 1 (type-specific data).
REQ-011 SHALL: chk_ok  output  1  checksum verified over all 5 words.
REQ-012 SHALL: is_echo_req  output  1  type 8, code 0 and chk_ok.
REQ-013 SHALL: good_cnt / bad_cnt / abort_cnt  output  16 each  saturating statistics.

Function
REQ-014 SHALL: message = exactly 5 words (160 bits); words 2-4 are consumed into the checksum only.
REQ-015 SHALL: FSM states IDLE, COLLECT, CHECK, HOLD.
REQ-016 SHALL: IDLE: in_ready=1; word with in_sop -> clear accumulator, add halfwords, word index=1, go COLLECT; word without in_sop dropped, no count change.
REQ-017 SHALL: COLLECT: in_ready=1; each accepted word adds both halfwords, index increments; acceptance of word 4 -> CHECK.
REQ-018 SHALL: COLLECT with in_sop on accepted word: abort partial message, abort_cnt+1, restart at word 0 with that word.
REQ-019 SHALL: accumulator 20 bits, adds [31:16] and [15:0] of each word in the acceptance cycle.
REQ-020 SHALL: CHECK (1 cycle): fold twice (acc[15:0]+acc[19:16]); chk_ok = (result == 16'hFFFF); good_cnt or bad_cnt +1; go HOLD.
REQ-021 SHALL: HOLD: out_valid=1, outputs stable until out_ready sampled high, then IDLE.
REQ-022 SHALL: latency: word 4 accepted at edge N -> out_valid high after edge N+2.
REQ-023 SHALL: in_ready=0 in CHECK and HOLD; no input is lost (upstream stalls).
REQ-024 SHALL: counters saturate at 16'hFFFF and do not wrap.
REQ-025 SHALL: out_valid=1 with out_ready=1 in the same cycle as an in_sop: in_sop is not accepted that cycle (in_ready still 0).

Reset
REQ-026 SHALL: actreset forces IDLE; in_ready=0 while asserted, 1 after release.
REQ-027 SHALL: reset values: out_valid=0, msg_type=0, msg_code=0, msg_typedata=0, chk_ok=0, is_echo_req=0, all counters=0, accumulator=0.
REQ-028 SHALL: reset mid-message discards the partial message without counting it.

Structure
REQ-029 SHALL: shared package icmp_pkg holds state encodings, ICMP_WORDS=5, ICMP_TYPE_ECHO_REQ=8, ICMP_TYPE_ECHO_REPLY=0.
REQ-030 SHALL: one sub-module icmp_csum_acc (clear, add 32-bit word, folded 16-bit result), reusable by the sender side.

Verification
REQ-031 SHALL: words 0800F7FC, 00010002, 0, 0, 0 with in_sop on word 0 -> out_valid, type 08, code 00, typedata 00010002, chk_ok=1, is_echo_req=1, good_cnt=1.
REQ-032 SHALL: same message with word 0 = 0800F7FD -> chk_ok=0, is_echo_req=0, bad_cnt=1.
REQ-033 SHALL: in_sop on the 3rd word of a message, then a full valid message -> abort_cnt=1, single good output.
REQ-034 SHALL: out_ready held 0 for 10 cycles -> in_ready=0 and outputs stable throughout; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL: actreset asserted after 2 words -> all outputs at reset values, next full message decoded correctly.
REQ-036 SHALL: 65540 bad messages -> bad_cnt saturates at FFFF.
